// File: rtl/an_code_pkg.sv
// Shared definitions for the AN-code decoders: default code parameters, the syndrome
// constant generator and the decoder state enumeration.
package an_code_pkg;

    localparam int unsigned DefNBits = 4;
    localparam int unsigned DefA     = 665;
    localparam int unsigned DefWBits = 14;

    typedef struct packed {
        logic [31:0] r;  // 2^i mod A
        logic [31:0] k;  // floor(2^i / A)
    } syn_entry_t;

    typedef enum logic [1:0] {
        StIdle,
        StDiv,
        StCorr,
        StDone
    } dec_state_e;

    function automatic syn_entry_t syn_entry(input int unsigned a, input int unsigned i);
        longint unsigned p;
        syn_entry_t      e;
        p   = 64'd1 << i;
        e.r = 32'(p % 64'(a));
        e.k = 32'(p / 64'(a));
        return e;
    endfunction

endpackage

// File: rtl/an_sec_decoder_seq_if.sv
// Codeword-in / decoded-result-out handshake bundle for the sequential AN decoder.
interface an_sec_decoder_seq_if
    import an_code_pkg::*;
#(
    parameter int unsigned N_BITS = DefNBits,
    parameter int unsigned W_BITS = DefWBits
) ();

    localparam int unsigned PosBits = $clog2(W_BITS);

    logic               in_valid;
    logic               in_ready;
    logic [W_BITS-1:0]  in_w;
    logic               out_valid;
    logic               out_ready;
    logic [N_BITS-1:0]  out_n;
    logic               out_corrected;
    logic               out_uncorrectable;
    logic [PosBits-1:0] out_err_pos;
    logic               out_err_neg;

    modport master (
        output in_valid, in_w, out_ready,
        input  in_ready, out_valid, out_n, out_corrected, out_uncorrectable,
               out_err_pos, out_err_neg
    );

    modport slave (
        input  in_valid, in_w, out_ready,
        output in_ready, out_valid, out_n, out_corrected, out_uncorrectable,
               out_err_pos, out_err_neg
    );

endinterface

// File: rtl/an_mod_divider_seq.sv
// Restoring divider by the constant A: one quotient bit per cycle, MSB first.
module an_mod_divider_seq
    import an_code_pkg::*;
#(
    parameter int unsigned W_BITS = DefWBits,
    parameter int unsigned A      = DefA
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [W_BITS-1:0] dividend,
    output logic              done,
    output logic [W_BITS-1:0] quotient,
    output logic [W_BITS-1:0] remainder
);

    localparam int unsigned   CntBits = $clog2(W_BITS);
    localparam logic [W_BITS:0] Divisor = (W_BITS + 1)'(A);

    logic [W_BITS-1:0]  shift_q;
    logic [W_BITS-1:0]  quot_q;
    logic [W_BITS-1:0]  rem_q;
    logic [CntBits-1:0] cnt_q;
    logic               busy_q;

    logic [W_BITS:0]    trial;
    logic               fits;
    logic [W_BITS:0]    diff;
    logic [W_BITS-1:0]  rem_d;

    always_comb begin
        trial = {rem_q, shift_q[W_BITS-1]};
        fits  = trial >= Divisor;
        diff  = trial - Divisor;
        rem_d = fits ? diff[W_BITS-1:0] : trial[W_BITS-1:0];
    end

    // High during the final iteration; quotient/remainder are final from the next cycle.
    assign done      = busy_q && (cnt_q == '0);
    assign quotient  = quot_q;
    assign remainder = rem_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else if (start) begin
            shift_q <= dividend;
            quot_q  <= '0;
            rem_q   <= '0;
            cnt_q   <= CntBits'(W_BITS - 1);
            busy_q  <= 1'b1;
        end else if (busy_q) begin
            shift_q <= {shift_q[W_BITS-2:0], 1'b0};
            quot_q  <= {quot_q[W_BITS-2:0], fits};
            rem_q   <= rem_d;
            if (cnt_q == '0) begin
                busy_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/an_sec_decoder_seq.sv
// Sequential AN-code single-error-correcting decoder: divide W by A, then correct a
// single +/-2^i error from the remainder syndrome.
module an_sec_decoder_seq
    import an_code_pkg::*;
#(
    parameter int unsigned N_BITS = DefNBits,
    parameter int unsigned A      = DefA,
    parameter int unsigned W_BITS = DefWBits
) (
    input logic                 clk,
    input logic                 rst,
    an_sec_decoder_seq_if.slave bus
);

    localparam int unsigned PosBits  = $clog2(W_BITS);
    localparam int unsigned CalcBits = W_BITS + 2;

    dec_state_e         state;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [N_BITS-1:0]  out_n_q;
    logic               out_corrected_q;
    logic               out_uncorrectable_q;
    logic [PosBits-1:0] out_err_pos_q;
    logic               out_err_neg_q;

    logic               div_start;
    logic               div_done;
    logic [W_BITS-1:0]  quot;
    logic [W_BITS-1:0]  rem;

    assign div_start = (state == StIdle) && bus.in_valid;

    an_mod_divider_seq #(
        .W_BITS (W_BITS),
        .A      (A)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .dividend  (bus.in_w),
        .done      (div_done),
        .quotient  (quot),
        .remainder (rem)
    );

    logic [W_BITS-1:0] syn_r     [W_BITS];
    logic [W_BITS-1:0] syn_neg_r [W_BITS];
    logic [W_BITS-1:0] syn_k     [W_BITS];

    for (genvar i = 0; i < W_BITS; i++) begin : g_syn
        localparam syn_entry_t Entry = syn_entry(A, i);
        assign syn_r[i]     = W_BITS'(Entry.r);
        assign syn_neg_r[i] = W_BITS'(A - Entry.r);
        assign syn_k[i]     = W_BITS'(Entry.k);
    end

    logic               pos_hit;
    logic               neg_hit;
    logic [PosBits-1:0] hit_idx;
    logic [W_BITS-1:0]  hit_k;
    logic [CalcBits-1:0] q_ext;
    logic [CalcBits-1:0] k_ext;
    logic [CalcBits-1:0] n_calc;
    logic               n_in_range;
    logic               correctable;

    // Scanning downwards leaves the lowest matching index; positive scan runs last to win.
    always_comb begin
        pos_hit = 1'b0;
        neg_hit = 1'b0;
        hit_idx = '0;
        hit_k   = '0;
        for (int i = int'(W_BITS) - 1; i >= 0; i--) begin
            if (rem == syn_neg_r[i]) begin
                neg_hit = 1'b1;
                hit_idx = PosBits'(i);
                hit_k   = syn_k[i];
            end
        end
        for (int i = int'(W_BITS) - 1; i >= 0; i--) begin
            if (rem == syn_r[i]) begin
                pos_hit = 1'b1;
                hit_idx = PosBits'(i);
                hit_k   = syn_k[i];
            end
        end
        if (pos_hit) begin
            neg_hit = 1'b0;
        end

        q_ext = {2'b00, quot};
        k_ext = {2'b00, hit_k};
        if (pos_hit) begin
            n_calc = q_ext - k_ext;
        end else if (neg_hit) begin
            n_calc = q_ext + k_ext + CalcBits'(1);
        end else begin
            n_calc = q_ext;
        end
        // Two's-complement: sign bit clear and nothing above the N field.
        n_in_range  = !n_calc[CalcBits-1] && !(|n_calc[CalcBits-2:N_BITS]);
        correctable = (pos_hit || neg_hit) && n_in_range;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state               <= StIdle;
            in_ready_q          <= 1'b1;
            out_valid_q         <= 1'b0;
            out_n_q             <= '0;
            out_corrected_q     <= 1'b0;
            out_uncorrectable_q <= 1'b0;
            out_err_pos_q       <= '0;
            out_err_neg_q       <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (bus.in_valid) begin
                        state      <= StDiv;
                        in_ready_q <= 1'b0;
                    end
                end
                StDiv: begin
                    if (div_done) begin
                        state <= StCorr;
                    end
                end
                StCorr: begin
                    state               <= StDone;
                    out_valid_q         <= 1'b1;
                    out_n_q             <= n_calc[N_BITS-1:0];
                    out_corrected_q     <= correctable;
                    out_uncorrectable_q <= (rem != '0) && !correctable;
                    out_err_pos_q       <= correctable ? hit_idx : '0;
                    out_err_neg_q       <= correctable && neg_hit;
                end
                StDone: begin
                    if (bus.out_ready) begin
                        state       <= StIdle;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign bus.in_ready          = in_ready_q;
    assign bus.out_valid         = out_valid_q;
    assign bus.out_n             = out_n_q;
    assign bus.out_corrected     = out_corrected_q;
    assign bus.out_uncorrectable = out_uncorrectable_q;
    assign bus.out_err_pos       = out_err_pos_q;
    assign bus.out_err_neg       = out_err_neg_q;

endmodule

// File: tb/tb_an_sec_decoder_seq.sv
// Self-checking bench for an_sec_decoder_seq: directed vectors plus a per-result model check.
module tb_an_sec_decoder_seq;
    import an_code_pkg::*;

    localparam int NB  = 4;
    localparam int AA  = 665;
    localparam int WB  = 14;
    localparam int LAT = WB + 1;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    an_sec_decoder_seq_if #(.N_BITS(NB), .W_BITS(WB)) bus ();

    an_sec_decoder_seq #(
        .N_BITS (NB),
        .A      (AA),
        .W_BITS (WB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int n;
        bit corr;
        bit unc;
        int pos;
        bit neg;
    } exp_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Decoding rules in plain integer arithmetic.
    function automatic exp_t model(input int w);
        exp_t e;
        int q, r, hit, nn;
        bit neg;
        longint p;
        e   = '{n: 0, corr: 0, unc: 0, pos: 0, neg: 0};
        q   = w / AA;
        r   = w % AA;
        hit = -1;
        neg = 0;
        nn  = 0;
        if (r == 0) begin
            e.n = q % (1 << NB);
            return e;
        end
        for (int i = 0; i < WB; i++) begin
            p = longint'(1) << i;
            if (hit < 0 && r == int'(p % AA)) begin
                hit = i;
                nn  = q - int'(p / AA);
            end
        end
        for (int i = 0; i < WB; i++) begin
            p = longint'(1) << i;
            if (hit < 0 && r == AA - int'(p % AA)) begin
                hit = i;
                neg = 1;
                nn  = q + int'(p / AA) + 1;
            end
        end
        if (hit < 0) begin
            e.n   = q % (1 << NB);
            e.unc = 1;
        end else if (nn < 0 || nn > (1 << NB) - 1) begin
            e.n   = nn & ((1 << NB) - 1);
            e.unc = 1;
        end else begin
            e.n    = nn;
            e.corr = 1;
            e.pos  = hit;
            e.neg  = neg;
        end
        return e;
    endfunction

    exp_t expq[$];
    int   accq[$];
    bit   prev_valid = 0;

    always @(negedge clk) begin
        if (rst) begin
            expq.delete();
            accq.delete();
            prev_valid = 0;
        end else begin
            if (bus.out_valid) begin
                check("mon_pending", expq.size() != 0, 1);
                if (expq.size() != 0) begin
                    if (!prev_valid) check("mon_latency", cyc - accq[0], LAT);
                    check("mon_n", bus.out_n, expq[0].n);
                    check("mon_corrected", bus.out_corrected, expq[0].corr);
                    check("mon_uncorrectable", bus.out_uncorrectable, expq[0].unc);
                    check("mon_err_pos", bus.out_err_pos, expq[0].pos);
                    check("mon_err_neg", bus.out_err_neg, expq[0].neg);
                    check("mon_in_ready_busy", bus.in_ready, 0);
                    if (bus.out_ready) begin
                        void'(expq.pop_front());
                        void'(accq.pop_front());
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                expq.push_back(model(int'(bus.in_w)));
                accq.push_back(cyc + 1);
            end
            prev_valid = bus.out_valid;
        end
    end

    task automatic wait_result(input string tag);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!bus.out_valid && t < 50);
        check({tag, "_valid"}, bus.out_valid, 1);
    endtask

    task automatic send(input int w);
        int t;
        @(posedge clk);
        #1;
        bus.in_w     = WB'(w);
        bus.in_valid = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!bus.in_ready && t < 50);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic release_result();
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic decode(input string tag, input int w, input int en, input bit ec,
                          input bit eu, input int ep, input bit eneg);
        send(w);
        wait_result(tag);
        check({tag, "_n"}, bus.out_n, en);
        check({tag, "_corrected"}, bus.out_corrected, ec);
        check({tag, "_uncorrectable"}, bus.out_uncorrectable, eu);
        check({tag, "_err_pos"}, bus.out_err_pos, ep);
        check({tag, "_err_neg"}, bus.out_err_neg, eneg);
        release_result();
    endtask

    initial begin
        int n, kind, bit_i, w, t;
        exp_t m;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_w      = '0;
        bus.out_ready = 1'b0;
        #12;
        check("reset_in_ready", bus.in_ready, 1);
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_out_n", bus.out_n, 0);
        check("reset_flags", {bus.out_corrected, bus.out_uncorrectable, bus.out_err_neg}, 0);
        check("reset_err_pos", bus.out_err_pos, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        decode("clean", 4655, 7, 0, 0, 0, 0);
        decode("pos3", 4663, 7, 1, 0, 3, 0);
        decode("pos10", 5679, 7, 1, 0, 10, 0);
        decode("neg9", 4143, 7, 1, 0, 9, 1);
        decode("nomatch", 4658, 7, 0, 1, 0, 0);
        decode("range", 10639, 0, 0, 1, 0, 0);

        // Hold the result for five cycles while offering a different codeword.
        send(4663);
        wait_result("hold");
        bus.in_w     = WB'(4655);
        bus.in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("hold_valid", bus.out_valid, 1);
            check("hold_in_ready", bus.in_ready, 0);
            check("hold_n", bus.out_n, 7);
            check("hold_pos", bus.out_err_pos, 3);
            check("hold_corrected", bus.out_corrected, 1);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        release_result();
        repeat (20) @(negedge clk);
        check("ignored_in_valid", bus.out_valid, 0);

        // Reset in the middle of a division.
        send(4655);
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("midrst_in_ready", bus.in_ready, 1);
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_out_n", bus.out_n, 0);
        check("midrst_flags", {bus.out_corrected, bus.out_uncorrectable, bus.out_err_neg}, 0);
        check("midrst_err_pos", bus.out_err_pos, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        decode("after_rst", 4655, 7, 0, 0, 0, 0);

        // Streaming with out_ready held high.
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 100; k++) begin
            n     = $urandom_range(0, (1 << NB) - 1);
            kind  = $urandom_range(0, 2);
            bit_i = $urandom_range(0, WB - 1);
            w     = AA * n;
            if (kind == 1 && w + (1 << bit_i) < (1 << WB)) w = w + (1 << bit_i);
            else if (kind == 2 && w >= (1 << bit_i)) w = w - (1 << bit_i);
            m = model(w);
            check("model_stream_n", m.n, n);
            bus.in_w     = WB'(w);
            bus.in_valid = 1'b1;
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!bus.in_ready && t < 40);
            check("stream_accept", bus.in_ready, 1);
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        t = 0;
        while (expq.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("drain", expq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
